// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Instruction fetch stage. Owns the program counter, issues word reads to
//   instruction memory over a req/ack handshake, buffers returned words in a
//   prefetch FIFO and hands {pc, instruction} to the decode stage over a
//   valid/ready handshake. A redirect flushes the FIFO and restarts fetch.
//
//   Optional feature macro: IF_ALIGN_TRAP_EN
//     defined   : a misaligned redirect target traps into a sticky FAULT state
//     undefined : redirect_pc[1:0] is forced to zero, fault is tied low
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   imem_req/addr     read request and byte address (held until imem_ack)
//   imem_ack/rdata    read completion and returned word
//   redirect/_pc      one-cycle flush and new fetch target
//   instructionOut    FIFO head instruction (0 when instrValid is low)
//   pcOut             PC of the FIFO head (0 when instrValid is low)
//   instrValid        FIFO head valid
//   instrReady        decode accepts the head this cycle
//   fault             sticky misaligned-redirect trap

module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instructionOut,
    output logic [31:0] pcOut,
    output logic        instrValid,
    input  logic        instrReady,
    output logic        fault
);

    // state | meaning
    // IDLE  | no request outstanding (FIFO full or just out of reset)
    // REQ   | request for fetchPc outstanding; ack pushes into the FIFO
    // DROP  | squashed request still outstanding; its data is discarded
    // FAULT | misaligned redirect trapped; no new requests (macro build only)

`ifdef IF_ALIGN_TRAP_EN
    typedef enum logic [1:0] {IDLE, REQ, DROP, FAULT} fetchStateT;
`else
    typedef enum logic [1:0] {IDLE, REQ, DROP} fetchStateT;
`endif

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

    fetchStateT       state;
    logic [31:0]      fetchPc;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [CNT_W-1:0] count;
    logic [31:0]      pcMem    [FIFO_DEPTH];
    logic [31:0]      instrMem [FIFO_DEPTH];

    logic             redirectTaken;
    logic             push;
    logic             pop;
    logic [31:0]      targetPc;
    logic [CNT_W-1:0] countNext;
`ifdef IF_ALIGN_TRAP_EN
    logic             misaligned;
`endif

    always_comb begin
        targetPc = redirect_pc & 32'hFFFF_FFFC;
`ifdef IF_ALIGN_TRAP_EN
        misaligned    = redirect_pc[1:0] != 2'b00;
        redirectTaken = redirect && (state != FAULT);
`else
        redirectTaken = redirect;
`endif
        pop       = instrValid && instrReady;
        // An ack in the same cycle as a redirect belongs to the old stream.
        push      = (state == REQ) && imem_ack && !redirectTaken;
        countNext = count + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            fetchPc   <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            count     <= '0;
            rdPtr     <= '0;
            wrPtr     <= '0;
`ifdef IF_ALIGN_TRAP_EN
            fault     <= 1'b0;
`endif
        end else begin
            count <= countNext;
            if (push) begin
                wrPtr   <= wrPtr + PTR_W'(1);
                fetchPc <= fetchPc + 32'd4;
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end

            if (redirectTaken) begin
                // Flush wins over a same-cycle pop: the popped head is
                // consumed by decode, everything behind it is dropped.
                count   <= '0;
                rdPtr   <= '0;
                wrPtr   <= '0;
                fetchPc <= targetPc;
`ifdef IF_ALIGN_TRAP_EN
                if (misaligned) begin
                    state <= FAULT;
                    fault <= 1'b1;
                    // An in-flight request stays up until its ack arrives.
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                    end
                end else
`endif
                if (state == REQ && !imem_ack) begin
                    // Memory still owns the old request: hold req/addr.
                    state <= DROP;
                end else if (state == DROP) begin
                    if (imem_ack) begin
                        state     <= REQ;
                        imem_addr <= targetPc;
                    end
                end else begin
                    state     <= REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= targetPc;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (count < FULL) begin
                            state     <= REQ;
                            imem_req  <= 1'b1;
                            imem_addr <= fetchPc;
                        end
                    end
                    REQ: begin
                        if (imem_ack) begin
                            imem_addr <= fetchPc + 32'd4;
                            // The slot for the next word is reserved now,
                            // so a later push can never overflow.
                            if (countNext >= FULL) begin
                                state    <= IDLE;
                                imem_req <= 1'b0;
                            end
                        end
                    end
                    DROP: begin
                        if (imem_ack) begin
                            state     <= REQ;
                            imem_addr <= fetchPc;
                        end
                    end
`ifdef IF_ALIGN_TRAP_EN
                    FAULT: begin
                        if (imem_ack) begin
                            imem_req <= 1'b0;
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pcMem[wrPtr]    <= fetchPc;
            instrMem[wrPtr] <= imem_rdata;
        end
    end

    assign instrValid     = count != '0;
    assign instructionOut = instrValid ? instrMem[rdPtr] : 32'h0;
    assign pcOut          = instrValid ? pcMem[rdPtr]    : 32'h0;

`ifndef IF_ALIGN_TRAP_EN
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: a memory model answering addr ^ KEY with
// fixed or random latency, and a stream-level reference that knows which PC
// decode must see next (sequential +4, restarting at each redirect target).

module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;
`ifdef IF_ALIGN_TRAP_EN
    localparam bit MISALIGN_TRAPS = 1'b1;
`else
    localparam bit MISALIGN_TRAPS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] instructionOut;
    logic [31:0] pcOut;
    logic        instrValid;
    logic        instrReady = 1'b0;
    logic        fault;

    int checkCount = 0;
    int errorCount = 0;

    // reference model and memory model state
    logic [31:0] expPc = RESET_PC;
    logic        modelFault = 1'b0;
    int          acceptCount = 0;
    int          ackCount = 0;
    int          memLat = 0;
    int          curLat = 0;
    int          waitCnt = 0;
    bit          memRandLat = 1'b0;
    bit          strayOn = 1'b0;
    logic        prevRst = 1'b1;
    logic        prevPending = 1'b0;
    logic [31:0] prevAddr = 32'h0;

    instruction_fetch #(
        .RESET_PC  (RESET_PC),
        .FIFO_DEPTH(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .instructionOut(instructionOut),
        .pcOut         (pcOut),
        .instrValid    (instrValid),
        .instrReady    (instrReady),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Stream checker + memory responder, evaluated mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            expPc       = RESET_PC;
            modelFault  = 1'b0;
            acceptCount = 0;
            ackCount    = 0;
            imem_ack    = 1'b0;
            imem_rdata  = 32'h0;
            waitCnt     = 0;
            curLat      = memLat;
            prevPending = 1'b0;
        end else begin
            if (prevPending) begin
                checkVal("holdReq", imem_req, 1'b1);
                checkVal("holdAddr", imem_addr, prevAddr);
            end
            checkVal("fault", fault, modelFault);
            if (!instrValid) begin
                checkVal("idleInstr", instructionOut, 32'h0);
                checkVal("idlePc", pcOut, 32'h0);
            end
            if (modelFault) checkVal("faultValid", instrValid, 1'b0);
            if (instrValid && instrReady) begin
                checkVal("streamPc", pcOut, expPc);
                checkVal("streamInstr", instructionOut, expPc ^ KEY);
                expPc = expPc + 32'd4;
                acceptCount++;
            end
            if (redirect && !modelFault) begin
                if (MISALIGN_TRAPS && redirect_pc[1:0] != 2'b00) modelFault = 1'b1;
                else expPc = redirect_pc & 32'hFFFF_FFFC;
            end

            if (strayOn && prevRst && !imem_req) begin
                // leftover ack from a transfer cut short by reset
                imem_ack   = 1'b1;
                imem_rdata = 32'hDEAD_BEEF;
                waitCnt    = 0;
            end else if (imem_req) begin
                if (waitCnt >= curLat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = imem_addr ^ KEY;
                    waitCnt    = 0;
                    curLat     = memRandLat ? int'($urandom_range(0, 3)) : memLat;
                end else begin
                    imem_ack = 1'b0;
                    waitCnt++;
                end
            end else begin
                imem_ack = 1'b0;
                waitCnt  = 0;
            end
            if (imem_req && imem_ack) ackCount++;
            prevPending = imem_req && !imem_ack;
            prevAddr    = imem_addr;
        end
        prevRst = rst;
    end

    task automatic doReset(input int cycles);
        @(posedge clk); #1;
        rst      = 1'b1;
        redirect = 1'b0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        checkVal("rstReq", imem_req, 1'b0);
        checkVal("rstAddr", imem_addr, RESET_PC);
        checkVal("rstValid", instrValid, 1'b0);
        checkVal("rstInstr", instructionOut, 32'h0);
        checkVal("rstPc", pcOut, 32'h0);
        checkVal("rstFault", fault, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic waitValid(input string tag);
        int n = 0;
        @(negedge clk);
        while (!instrValid && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkVal(tag, instrValid, 1'b1);
    endtask

    task automatic waitAddr(input string tag, input logic [31:0] addr);
        int n = 0;
        @(negedge clk);
        while (!(imem_req && imem_addr == addr) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkVal(tag, imem_addr, addr);
    endtask

    task automatic waitAccepts(input string tag, input int target);
        int n = 0;
        @(negedge clk);
        while (acceptCount < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkVal(tag, 32'(acceptCount >= target), 32'd1);
    endtask

    task automatic randomRun(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            instrReady = ($urandom_range(0, 9) < 7);
            if (redirect) begin
                redirect = 1'b0;
            end else if ($urandom_range(0, 19) == 0) begin
                redirect    = 1'b1;
                redirect_pc = 32'($urandom_range(0, 1023));
                if (MISALIGN_TRAPS) redirect_pc[1:0] = 2'b00;
            end
        end
        @(posedge clk); #1;
        redirect = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int accBefore;
        logic reqSeen;

        // zero-wait memory, decode always ready
        memLat = 0; memRandLat = 1'b0; strayOn = 1'b0; instrReady = 1'b1;
        doReset(3);
        @(negedge clk);
        checkVal("reqCycle1", imem_req, 1'b0);
        @(negedge clk);
        checkVal("reqCycle2", imem_req, 1'b1);
        checkVal("addrFirst", imem_addr, RESET_PC);
        waitValid("firstValid");
        checkVal("seqPc0", pcOut, 32'h0);
        checkVal("seqInstr0", instructionOut, 32'h0 ^ KEY);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            checkVal("seqValid", instrValid, 1'b1);
            checkVal("seqPc", pcOut, 32'(4 * i));
            checkVal("seqInstr", instructionOut, 32'(4 * i) ^ KEY);
        end

        // backpressure: FIFO fills, fetch stops, then drains and resumes
        instrReady = 1'b0;
        doReset(2);
        repeat (12) @(negedge clk);
        #2;
        checkVal("fullAcks", ackCount, 32'd4);
        checkVal("fullReq", imem_req, 1'b0);
        checkVal("fullValid", instrValid, 1'b1);
        checkVal("fullPc", pcOut, 32'h0);
        @(posedge clk); #1;
        instrReady = 1'b1;
        waitAccepts("drainResume", 5);

        // slow memory, redirect while request at 8 is in flight
        memLat = 3;
        doReset(2);
        waitAddr("reqAt8", 32'h8);
        @(posedge clk); #1;
        redirect = 1'b1; redirect_pc = 32'h100;
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk);
        checkVal("dropReq", imem_req, 1'b1);
        checkVal("dropAddr", imem_addr, 32'h8);
        waitAddr("reqAt100", 32'h100);
        waitValid("valid100");
        checkVal("pcAfterDrop", pcOut, 32'h100);

        // redirect coinciding with ack and pop
        memLat = 0;
        doReset(2);
        waitAccepts("warm", 3);
        @(posedge clk); #1;
        redirect = 1'b1; redirect_pc = 32'h40;
        @(negedge clk); #2;
        checkVal("ackPopSetup", {29'h0, imem_ack, instrValid, instrReady}, 32'h7);
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk);
        checkVal("flushValid", instrValid, 1'b0);
        checkVal("redirReq", imem_req, 1'b1);
        checkVal("redirAddr", imem_addr, 32'h40);
        waitValid("valid40");
        checkVal("pcAfter40", pcOut, 32'h40);

        // randomized traffic, with a reset in the middle of a transfer
        memRandLat = 1'b1; strayOn = 1'b1;
        doReset(2);
        randomRun(1500);
        begin
            int n = 0;
            while (!imem_req && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        accBefore = acceptCount;
        doReset(2);
        randomRun(1500);
        checkVal("progress", 32'(accBefore + acceptCount >= 200), 32'd1);

        // misaligned redirect target
        memRandLat = 1'b0; strayOn = 1'b0; memLat = 0; instrReady = 1'b1;
        doReset(2);
        waitAccepts("warm2", 2);
        @(posedge clk); #1;
        redirect = 1'b1; redirect_pc = 32'h102;
        @(posedge clk); #1;
        redirect = 1'b0;
        if (MISALIGN_TRAPS) begin
            @(negedge clk);
            checkVal("trapFault", fault, 1'b1);
            checkVal("trapValid", instrValid, 1'b0);
            reqSeen = 1'b0;
            repeat (5) begin
                @(negedge clk);
                reqSeen = reqSeen | imem_req;
            end
            @(posedge clk); #1;
            redirect = 1'b1; redirect_pc = 32'h200;
            @(posedge clk); #1;
            redirect = 1'b0;
            repeat (6) begin
                @(negedge clk);
                reqSeen = reqSeen | imem_req;
            end
            checkVal("trapNoReq", reqSeen, 1'b0);
            checkVal("trapSticky", fault, 1'b1);
            checkVal("trapIgnore", instrValid, 1'b0);
        end else begin
            waitValid("validAligned");
            checkVal("alignedPc", pcOut, 32'h100);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch (IF) stage: owns the program counter, issues word reads to instruction memory over a req/ack handshake, buffers returned words in a small prefetch FIFO, and presents them with their PC to the ID stage over a valid/ready handshake. It is the producer end of the `instructionIn` path into ID. Branch/jump resolution downstream redirects it with a flush.

## Interface
- `RESET_PC`, 32'h0000_0000, PC of the first fetch after reset (word aligned)
- `FIFO_DEPTH`, 4, prefetch entries; power of two, ≥2
- `clk`  in  1  clock, all logic rising-edge
- `rst`  in  1  synchronous, active-high reset
- `imem_req`  out  1  read request; held until `imem_ack`
- `imem_addr`  out  32  byte address; stable while `imem_req` high
- `imem_ack`  in  1  read complete this cycle; may be high in the same cycle `imem_req` rises
- `imem_rdata`  in  32  read word, valid when `imem_ack`
- `redirect`  in  1  one-cycle flush + new PC
- `redirect_pc`  in  32  target PC, sampled when `redirect`
- `instructionOut`  out  32  FIFO head instruction to ID
- `pcOut`  out  32  PC of `instructionOut`
- `instrValid`  out  1  head valid
- `instrReady`  in  1  ID accepts head this cycle
- `fault`  out  1  misaligned redirect (only with `IF_ALIGN_TRAP_EN`; else tied 0)

## Operation
- Registers: `fetch_pc`, FIFO of {pc, instr}, `count`, state.
- States: IDLE (no request), REQ (`imem_req`=1, `imem_addr`=`fetch_pc`), DROP (`imem_req`=1 for a squashed request, response discarded), FAULT (macro only).
- IDLE→REQ when `count` < FIFO_DEPTH and no redirect.
- REQ on `imem_ack`: push {`fetch_pc`, `imem_rdata`}, `fetch_pc` += 4 (mod 2^32); stay REQ if post-push/pop `count` < FIFO_DEPTH, else IDLE. One request outstanding max; slot reserved at issue so push never overflows.
- Pop when `instrValid` && `instrReady`. Push and pop in the same cycle: `count` unchanged, also legal at full.
- `instrValid` = `count` != 0; `instructionOut`/`pcOut` = 0 when `instrValid` low.
- Redirect (any state but FAULT): FIFO flushed (`count`=0), `fetch_pc` = `redirect_pc`. If state REQ and no `imem_ack` this cycle → DROP. Otherwise (IDLE, or REQ with `imem_ack` this cycle) → REQ; acked word discarded, not pushed.
- DROP: keep `imem_req`/`imem_addr` of the squashed request; on `imem_ack` discard data → REQ. Redirect in DROP only updates `fetch_pc`.
- Redirect beats pop in the same cycle: popped entry is consumed by ID, everything else flushed.
- Reset mid-transfer: state IDLE immediately; a pending memory ack after reset is ignored.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=RESET_PC, `instrValid`=0, `instructionOut`=0, `pcOut`=0, `fault`=0, `count`=0, state IDLE.
- First `imem_req` high in the 2nd cycle after `rst` falls.
- `imem_ack` at edge N → `instrValid` high in cycle N+1 (1-cycle latency).
- Zero-wait memory (ack same cycle as req): one instruction per cycle sustained while ID ready.
- Redirect at edge N, no request in flight → `imem_addr`=`redirect_pc` with `imem_req`=1 in cycle N+1; `instrValid`=0 in N+1.
- No combinational path from `instrReady` to `imem_req`.

## Configuration
- `IF_ALIGN_TRAP_EN` defined: redirect with `redirect_pc[1:0]`≠0 flushes FIFO, enters FAULT; `fault`=1 from next cycle, sticky until `rst`; no further requests (an in-flight request is held until ack and discarded); redirects ignored in FAULT.
- Undefined: `redirect_pc[1:0]` forced to 0; `fault` constant 0; no FAULT state.

## Test plan
- Reset, RESET_PC=0, zero-wait memory returning addr^32'hA5A5_0000, `instrReady`=1 → `pcOut` 0,4,8,12 on consecutive cycles, `instructionOut` matching.
- `instrReady`=0, ack every cycle → exactly 4 pushes, `imem_req` low after 4th ack, `instrValid` held with `pcOut`=0; raise ready → drains 0,4,8,12 then fetch resumes at 16.
- 3-cycle memory latency, redirect to 32'h100 one cycle after req at 8 → DROP, req at 8 held until ack, data discarded, next req addr 32'h100, first `pcOut` 32'h100.
- Redirect to 32'h40 in the same cycle as ack and pop → acked word not output, `instrValid`=0 next cycle, next `pcOut` 32'h40.
- With `IF_ALIGN_TRAP_EN`: redirect to 32'h102 → `fault`=1 next cycle, `imem_req` stays 0 thereafter, later redirect to 32'h200 ignored; without macro: fetch at 32'h100.
